dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single data-memory port (combinational read, write on clock edge, MMIO at 0x4000000C/0x40000010) between the CPU pipeline MEM stage (port 0) and the DMA/UART loader (port 1).
- Registers the winning request, drives the memory for one access cycle, then returns a registered ack and read data to the winner.
- Round-robin by default; the optional macro selects fixed CPU priority instead.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MMIO_BASE, 32'h40000000, port 1 addresses >= this are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- p0_req / p1_req  in  1  level request, held until ack.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  ADDR_W  byte address.
- p0_wdata / p1_wdata  in  DATA_W  write data.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_rdata / p1_rdata  out  DATA_W  read data, valid when ack=1.
- p1_err  out  1  pulses with p1_ack when a port 1 access was rejected.
- mem_addr  out  ADDR_W  to Address.
- mem_wdata  out  DATA_W  to Write_data.
- mem_read  out  1  to MemRead.
- mem_write  out  1  to MemWrite.
- mem_rdata  in  DATA_W  from Read_data.

Behaviour:
- States: IDLE, ACCESS. All outputs are registered.
- Reset values: IDLE; all ack and err = 0; all rdata = 0; mem_addr, mem_wdata = 0; mem_read = mem_write = 0; last-grant pointer = 1, so port 0 wins the first tie.
- IDLE, no request: stay in IDLE; mem_read = mem_write = 0.
- IDLE, request present at edge N:
  - Pick the winner and latch its addr/wdata/we into mem_addr, mem_wdata, mem_write = we, mem_read = ~we.
  - Go to ACCESS and update the last-grant pointer.
- ACCESS (cycle N..N+1): memory is driven from the latched registers.
  - At edge N+1: the write commits in memory; mem_rdata is captured into the winner's rdata (reads only; rdata holds its old value on writes); the winner's ack = 1 for exactly one cycle.
  - Latency from request sampled to ack = 2 cycles.
- Back-to-back: at edge N+1 a request from the loser is latched directly, ACCESS → ACCESS with no IDLE bubble. The winner's own req is masked at that edge. Otherwise go to IDLE.
- Request accounting: each ack consumes one request. A requester still holding req in its ack cycle issues a new request, sampled at the next edge.
- Tie rule (round-robin): if both requests are present, grant the port not granted last. A lone requester is always granted.
- Port 1 MMIO guard: a port 1 request with addr >= MMIO_BASE still passes through ACCESS but drives mem_read = mem_write = 0. At the end of ACCESS: p1_ack = 1, p1_err = 1, p1_rdata = 0. Port 0 is never rejected.
- Address/data pass through unmodified; word alignment is the requester's responsibility.
- Inputs are sampled only at grant; changes during ACCESS have no effect.
- Reset mid-ACCESS: mem_write clears asynchronously, so no write commits. The pending request is dropped with no ack; the requester re-requests after reset.

Optional Feature:
- Macro: DMEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. Port 0 wins every tie, including back-to-back, and the last-grant pointer is not implemented. Port 1 can starve while p0_req is held.
- Undefined: round-robin as above.

Test Plan:
- Port 0 write 0xDEADBEEF to 0x00000010, then read it back → p0_ack 2 cycles after each req sample; p0_rdata = 0xDEADBEEF on the read ack; mem_write high for exactly 1 cycle.
- Both ports read together from reset (p0 addr 0x0 → 76, p1 addr 0x400 → 85) → p0 acked first, then p1 on the very next cycle; grants alternate 0,1,0,1 while both are held.
- Port 1 writes 0x1234 to 0x4000000C → p1_ack = 1 and p1_err = 1; mem_write never asserted; a following port 0 read of 0x4000000C returns 0.
- Port 0 writes 0x00FF to 0x40000010, then reads it → accepted, p0_rdata = 0x000000FF, no err.
- Port 1 write issued, reset driven low mid-ACCESS → mem_write drops immediately; no ack; a subsequent read shows the location unchanged.
- With DMEM_ARB_CPU_PRIO_EN defined, both requests held for 6 grants → all 6 go to port 0 and p1_ack stays 0; drop p0_req → p1 is granted on the next edge.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory (CPU MEM stage = port 0, loader = port 1).
// Round-robin by default; define DMEM_ARB_CPU_PRIO_EN for fixed port 0 priority.
module dmem_arbiter #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] MMIO_BASE = 32'h4000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t state_r;
   logic   cur_port_r;
   logic   cur_we_r;
   logic   cur_rej_r;
`ifndef DMEM_ARB_CPU_PRIO_EN
   logic   last_r;
`endif

   logic              in_access_s;
   logic              req0_s;
   logic              req1_s;
   logic              any_req_s;
   logic              grant_s;
   logic              sel_we_s;
   logic              rej_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;

   // Arbitration: the port finishing its access has its own request masked
   always_comb begin
      in_access_s = (state_r == ACCESS);
`ifdef DMEM_ARB_CPU_PRIO_EN
      req0_s = p0_req;
`else
      req0_s = p0_req & ~(in_access_s & ~cur_port_r);
`endif
      req1_s    = p1_req & ~(in_access_s & cur_port_r);
      any_req_s = req0_s | req1_s;
      if (req0_s && req1_s) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
         grant_s = 1'b0;
`else
         grant_s = ~last_r;
`endif
      end else if (req1_s) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
      if (grant_s) begin
         sel_addr_s  = p1_addr;
         sel_wdata_s = p1_wdata;
         sel_we_s    = p1_we;
         rej_s       = (p1_addr >= MMIO_BASE);
      end else begin
         sel_addr_s  = p0_addr;
         sel_wdata_s = p0_wdata;
         sel_we_s    = p0_we;
         rej_s       = 1'b0;
      end
   end

   // Grant/access FSM with registered memory strobes and per-port responses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         cur_port_r <= 1'b0;
         cur_we_r   <= 1'b0;
         cur_rej_r  <= 1'b0;
`ifndef DMEM_ARB_CPU_PRIO_EN
         last_r     <= 1'b1;
`endif
         p0_ack     <= 1'b0;
         p1_ack     <= 1'b0;
         p1_err     <= 1'b0;
         p0_rdata   <= {DATA_W{1'b0}};
         p1_rdata   <= {DATA_W{1'b0}};
         mem_addr   <= {ADDR_W{1'b0}};
         mem_wdata  <= {DATA_W{1'b0}};
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
      end else begin
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         p1_err <= 1'b0;
         if (state_r == ACCESS) begin
            if (cur_port_r) begin
               p1_ack <= 1'b1;
               p1_err <= cur_rej_r;
               if (cur_rej_r) begin
                  p1_rdata <= {DATA_W{1'b0}};
               end else if (!cur_we_r) begin
                  p1_rdata <= mem_rdata;
               end else begin
                  p1_rdata <= p1_rdata;
               end
            end else begin
               p0_ack <= 1'b1;
               if (!cur_we_r) begin
                  p0_rdata <= mem_rdata;
               end else begin
                  p0_rdata <= p0_rdata;
               end
            end
         end else begin
            p1_rdata <= p1_rdata;
         end
         if (any_req_s) begin
            state_r    <= ACCESS;
            cur_port_r <= grant_s;
            cur_we_r   <= sel_we_s;
            cur_rej_r  <= rej_s;
`ifndef DMEM_ARB_CPU_PRIO_EN
            last_r     <= grant_s;
`endif
            mem_addr   <= sel_addr_s;
            mem_wdata  <= sel_wdata_s;
            // A rejected MMIO access from the loader runs a dead cycle with no strobes
            mem_write  <= sel_we_s & ~rej_s;
            mem_read   <= ~sel_we_s & ~rej_s;
         end else begin
            state_r   <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data memory, vector table driven through a response scoreboard,
// plus hand sequences for tie alternation, reset mid-access and (if DMEM_ARB_CPU_PRIO_EN) fixed priority.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        preload = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0, p1_addr = 32'h0, p1_wdata = 32'h0;
   logic        p0_ack, p1_ack, p1_err, mem_read, mem_write;
   logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   logic [31:0] shadow [0:1];
   logic [31:0] mem [0:1023];

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
      int          wr;
      int          rd;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[12];

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic int midx(input logic [31:0] a);
      return int'({a[30], a[10:2]});
   endfunction

   assign mem_rdata = mem[midx(mem_addr)];

   // Data memory: combinational read, write on the clock edge
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         mem[midx(32'h0000_0000)] <= 32'd76;
         mem[midx(32'h0000_0400)] <= 32'd85;
      end else if (mem_write) begin
         mem[midx(mem_addr)] <= mem_wdata;
      end
   end

   // Strobe counters sampled mid-cycle
   always @(negedge clk) begin
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (mem_read) rd_cnt <= rd_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_port(input logic port, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic compare_ack(input int wr0, input int rd0);
      exp_t e;
      e = sbq.pop_front();
      check("ack_port", {31'h0, p1_ack}, {31'h0, e.port});
      check("single_ack", {31'h0, p0_ack & p1_ack}, 32'h0);
      check("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
      check("err", {31'h0, p1_err}, {31'h0, e.err});
      check("wr_pulses", wr_cnt - wr0, e.wr);
      check("rd_pulses", rd_cnt - rd0, e.rd);
      shadow[e.port] = e.rdata;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   wr0, rd0;
      logic seen;
      e.port  = v.port;
      e.err   = v.port && (v.addr >= 32'h4000_0000);
      e.rdata = e.err ? 32'h0 : (v.we ? shadow[v.port] : v.rdata);
      e.wr    = (v.we && !e.err) ? 1 : 0;
      e.rd    = (!v.we && !e.err) ? 1 : 0;
      sbq.push_back(e);
      wr0  = wr_cnt;
      rd0  = rd_cnt;
      seen = 1'b0;
      set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
      for (int c = 1; c <= 8 && !seen; c++) begin
         tick();
         if (p0_ack || p1_ack) begin
            seen = 1'b1;
            check("latency", c, 32'd2);
            set_port(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
            compare_ack(wr0, rd0);
         end
      end
      if (!seen) begin
         check("ack_seen", 32'h0, 32'h1);
         set_port(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
         void'(sbq.pop_front());
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 1'b1, 32'h4000_000C, 32'h0000_1234, 32'h0};
      vecs[3]  = '{1'b0, 1'b0, 32'h4000_000C, 32'h0,         32'h0};
      vecs[4]  = '{1'b0, 1'b1, 32'h4000_0010, 32'h0000_00FF, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 32'h4000_0010, 32'h0,         32'h0000_00FF};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'd76};
      vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_55AA, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_55AA};
      vecs[9]  = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         32'd85};
      vecs[10] = '{1'b1, 1'b0, 32'h4000_0000, 32'h0,         32'h0};
      vecs[11] = '{1'b1, 1'b0, 32'h3FFF_FFFC, 32'h0,         32'h0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_p0_ack", {31'h0, p0_ack}, 32'h0);
      check("rst_p1_ack", {31'h0, p1_ack}, 32'h0);
      check("rst_p1_err", {31'h0, p1_err}, 32'h0);
      check("rst_p0_rdata", p0_rdata, 32'h0);
      check("rst_p1_rdata", p1_rdata, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
      preload = 1'b0;
      reset   = 1'b1;
      tick();

`ifndef DMEM_ARB_CPU_PRIO_EN
      // Both ports hold read requests from reset: grants alternate 0,1,0,1,...
      set_port(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
      set_port(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
      tick();
      check("tie_no_early_ack", {30'h0, p0_ack, p1_ack}, 32'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("tie_ack", {31'h0, p0_ack | p1_ack}, 32'h1);
         check("tie_port", {31'h0, p1_ack}, i % 2);
         if (i == 0) check("tie_p0_rdata", p0_rdata, 32'd76);
         if (i == 1) check("tie_p1_rdata", p1_rdata, 32'd85);
      end
      set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      check("tie_drain_p0", {31'h0, p0_ack}, 32'h1);
      tick();
      tick();
      shadow[0] = 32'd76;
      shadow[1] = 32'd85;

      for (int k = 0; k < 12; k++) run_vec(vecs[k]);

      // Reset during a port 1 write access: strobe drops at once, no ack, no commit
      set_port(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0BAD);
      tick();
      check("mid_mem_write_on", {31'h0, mem_write}, 32'h1);
      #2 reset = 1'b0;
      #1 check("mid_mem_write_async", {31'h0, mem_write}, 32'h0);
      tick();
      check("mid_no_ack", {30'h0, p0_ack, p1_ack}, 32'h0);
      set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      reset = 1'b1;
      tick();
      shadow[0] = 32'h0;
      shadow[1] = 32'h0;
      run_vec(vecs[8]);
`else
      begin
         int   n0;
         logic p1_seen;
         logic got;
         n0 = 0;
         p1_seen = 1'b0;
         set_port(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
         set_port(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
         for (int c = 0; c < 20 && n0 < 6; c++) begin
            tick();
            if (p0_ack) n0++;
            if (p1_ack) p1_seen = 1'b1;
         end
         check("prio_p0_grants", n0, 32'd6);
         check("prio_p1_starved", {31'h0, p1_seen}, 32'h0);
         set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         got = 1'b0;
         for (int c = 0; c < 4 && !got; c++) begin
            tick();
            if (p1_ack) got = 1'b1;
         end
         check("prio_p1_after_drop", {31'h0, got}, 32'h1);
         check("prio_p1_rdata", p1_rdata, 32'd85);
         set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         tick();
         tick();
         shadow[0] = 32'd76;
         shadow[1] = 32'd85;
         for (int k = 0; k < 12; k++) run_vec(vecs[k]);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
